// File: rtl/bicubic_upsample_stream_pkg.sv
// Shared constants for the 4x bicubic upsampler.
// Weight sets, phase width and fixed-point scaling.
package bicubic_upsample_stream_pkg;

  localparam int PHASE_W     = 4;
  localparam int WT_W        = 9;
  localparam int SCALE_SHIFT = 14;
  localparam int ROUND_C     = 8192;

  // Bicubic taps; each set sums to 128, so the
  // centre tap of set 0 needs the ninth bit.
  function automatic logic signed [WT_W-1:0] bc_weight(
    input logic [1:0] ph,
    input logic [1:0] tap
  );
    logic signed [WT_W-1:0] w;
    case ({ph, tap})
      4'h0:    w = 9'sd0;
      4'h1:    w = 9'sd128;
      4'h2:    w = 9'sd0;
      4'h3:    w = 9'sd0;
      4'h4:    w = -9'sd9;
      4'h5:    w = 9'sd111;
      4'h6:    w = 9'sd29;
      4'h7:    w = -9'sd3;
      4'h8:    w = -9'sd8;
      4'h9:    w = 9'sd72;
      4'hA:    w = 9'sd72;
      4'hB:    w = -9'sd8;
      4'hC:    w = -9'sd3;
      4'hD:    w = 9'sd29;
      4'hE:    w = 9'sd111;
      default: w = -9'sd9;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bicubic_phase_mac.sv
// Separable 4x4 bicubic MAC for one channel.
// Horizontal then vertical pass, round, saturate.
module bicubic_phase_mac
  import bicubic_upsample_stream_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [15:0][CW-1:0] pix,
  input  logic [1:0]          i,
  input  logic [1:0]          j,
  input  logic                nearest,
  output logic [CW-1:0]       y
);

  localparam int HW = CW + 10;
  localparam int VW = CW + 18;

  logic signed [HW-1:0] h [4];
  logic signed [VW-1:0] v;
  logic signed [VW-1:0] vr;
  logic [CW-1:0]        sat;

  // Full-precision two-pass filter with rounding and clamp
  always_comb begin
    v = '0;
    for (int r = 0; r < 4; r++) begin
      h[r] = '0;
      for (int c = 0; c < 4; c++) begin
        h[r] = h[r]
          + HW'(bc_weight(j, 2'(c)))
          * HW'($signed({1'b0, pix[r*4+c]}));
      end
      v = v + VW'(bc_weight(i, 2'(r))) * VW'(h[r]);
    end
    vr = (v + VW'(ROUND_C)) >>> SCALE_SHIFT;
    if (vr < 0)
      sat = '0;
    else if (vr > VW'((1 << CW) - 1))
      sat = '1;
    else
      sat = vr[CW-1:0];
    y = nearest ? pix[5] : sat;
  end

endmodule

// File: rtl/bicubic_upsample_stream.sv
// 4x bicubic upsampler: one 4x4 window in,
// 16 phase pixels out over valid/ready.
module bicubic_upsample_stream
  import bicubic_upsample_stream_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8,
  parameter int CHANNELS      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [16*CHANNELS*CHANNEL_WIDTH-1:0] req_win,
  input  logic                req_nearest,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [CHANNELS*CHANNEL_WIDTH-1:0] rsp_data,
  output logic [PHASE_W-1:0]  rsp_phase,
  output logic                rsp_last
);

  localparam int WIN_W = 16 * CHANNELS * CHANNEL_WIDTH;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]         state_q;
  logic [PHASE_W-1:0] idx_q;
  logic [WIN_W-1:0]   win_q;
  logic               nearest_q;
  logic               busy;
  logic               at_end;
  logic               req_fire;
  logic               rsp_fire;

  assign busy     = (state_q == S_BUSY);
  assign at_end   = (idx_q == 4'd15);
  assign req_ready = !busy || (at_end && rsp_ready);
  assign req_fire = req_valid && req_ready;
  assign rsp_valid = busy;
  assign rsp_fire = busy && rsp_ready;
  assign rsp_phase = idx_q;
  assign rsp_last  = busy && at_end;

  // Window load, phase stepping and busy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      win_q     <= '0;
      nearest_q <= 1'b0;
    end else if (req_fire) begin
      state_q   <= S_BUSY;
      idx_q     <= '0;
      win_q     <= req_win;
      nearest_q <= req_nearest;
    end else if (rsp_fire) begin
      if (at_end) begin
        state_q <= S_IDLE;
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [15:0][CHANNEL_WIDTH-1:0] pix;

    // Gather this channel's 16 window pixels
    always_comb begin
      for (int p = 0; p < 16; p++)
        pix[p] = win_q[(p*CHANNELS+k)*CHANNEL_WIDTH
                       +: CHANNEL_WIDTH];
    end

    bicubic_phase_mac #(
      .CW(CHANNEL_WIDTH)
    ) u_mac (
      .pix     (pix),
      .i       (idx_q[3:2]),
      .j       (idx_q[1:0]),
      .nearest (nearest_q),
      .y       (rsp_data[k*CHANNEL_WIDTH +: CHANNEL_WIDTH])
    );
  end

endmodule
